// File: rtl/rv32torv16_packer.sv
// RV32I -> RVC streaming packer: compresses each accepted instruction when an exact
// RVC equivalent exists and packs the mixed 16/32-bit stream into 32-bit words.
module rv32torv16_packer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_in_instr,
    input  logic        i_in_last,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_data,
    output logic [15:0] o_cmp_cnt
);

    typedef enum logic [1:0] {StEmpty, StHalf, StPad} state_e;

    localparam logic [6:0] OpImm   = 7'h13;
    localparam logic [6:0] OpReg   = 7'h33;
    localparam logic [6:0] OpLoad  = 7'h03;
    localparam logic [6:0] OpStore = 7'h23;
    localparam logic [6:0] OpJalr  = 7'h67;

    state_e      r_state;
    state_e      w_state_next;
    logic [15:0] r_hold;
    logic [15:0] w_hold_next;
    logic        r_out_valid;
    logic        w_out_valid_next;
    logic [31:0] r_out_data;
    logic [31:0] w_out_data_next;
    logic [15:0] r_cmp_cnt;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [11:0] w_imm_i;
    logic [11:0] w_imm_s;
    logic [5:0]  w_imm6;
    logic        w_imm6_ok;
    logic        w_same;
    logic        w_rd_p;
    logic        w_rs1_p;
    logic        w_rs2_p;
    logic        w_is_c;
    logic [15:0] w_c16;
    logic        w_out_free;
    logic        w_accept;

    assign w_opcode  = i_in_instr[6:0];
    assign w_rd      = i_in_instr[11:7];
    assign w_f3      = i_in_instr[14:12];
    assign w_rs1     = i_in_instr[19:15];
    assign w_rs2     = i_in_instr[24:20];
    assign w_f7      = i_in_instr[31:25];
    assign w_imm_i   = i_in_instr[31:20];
    assign w_imm_s   = {i_in_instr[31:25], i_in_instr[11:7]};
    assign w_imm6    = {i_in_instr[25], i_in_instr[24:20]};
    // imm fits in 6 signed bits when imm[11:5] is a pure sign extension
    assign w_imm6_ok = (w_f7 == 7'h00) || (w_f7 == 7'h7f);
    assign w_same    = (w_rd == w_rs1);
    assign w_rd_p    = (w_rd[4:3] == 2'b01);
    assign w_rs1_p   = (w_rs1[4:3] == 2'b01);
    assign w_rs2_p   = (w_rs2[4:3] == 2'b01);

    always_comb begin
        w_is_c = 1'b1;
        w_c16  = 16'h0000;
        if (i_in_instr == 32'h0000_0013) begin
            w_c16 = 16'h0001;
        end else if (i_in_instr == 32'h0010_0073) begin
            w_c16 = 16'h9002;
        end else if (w_opcode == OpImm && w_f3 == 3'b000 && w_rs1 == 5'd0 && w_rd != 5'd0
                     && w_imm6_ok) begin
            w_c16 = {3'b010, w_imm6[5], w_rd, w_imm6[4:0], 2'b01};
        end else if (w_opcode == OpImm && w_f3 == 3'b000 && w_same && w_rd != 5'd0
                     && w_rd != 5'd2 && w_imm_i != 12'd0 && w_imm6_ok) begin
            w_c16 = {3'b000, w_imm6[5], w_rd, w_imm6[4:0], 2'b01};
        end else if (w_opcode == OpReg && w_f3 == 3'b000 && w_f7 == 7'h00 && w_rs1 == 5'd0
                     && w_rd != 5'd0 && w_rs2 != 5'd0) begin
            w_c16 = {4'b1000, w_rd, w_rs2, 2'b10};
        end else if (w_opcode == OpReg && w_f3 == 3'b000 && w_f7 == 7'h00 && w_same
                     && w_rd != 5'd0 && w_rs2 != 5'd0) begin
            w_c16 = {4'b1001, w_rd, w_rs2, 2'b10};
        end else if (w_opcode == OpReg && w_same && w_rd_p && w_rs2_p && w_f7 == 7'h20
                     && w_f3 == 3'b000) begin
            w_c16 = {6'b100011, w_rd[2:0], 2'b00, w_rs2[2:0], 2'b01};
        end else if (w_opcode == OpReg && w_same && w_rd_p && w_rs2_p && w_f7 == 7'h00
                     && w_f3 == 3'b100) begin
            w_c16 = {6'b100011, w_rd[2:0], 2'b01, w_rs2[2:0], 2'b01};
        end else if (w_opcode == OpReg && w_same && w_rd_p && w_rs2_p && w_f7 == 7'h00
                     && w_f3 == 3'b110) begin
            w_c16 = {6'b100011, w_rd[2:0], 2'b10, w_rs2[2:0], 2'b01};
        end else if (w_opcode == OpReg && w_same && w_rd_p && w_rs2_p && w_f7 == 7'h00
                     && w_f3 == 3'b111) begin
            w_c16 = {6'b100011, w_rd[2:0], 2'b11, w_rs2[2:0], 2'b01};
        end else if (w_opcode == OpImm && w_f3 == 3'b001 && w_f7 == 7'h00 && w_same
                     && w_rd != 5'd0 && w_rs2 != 5'd0) begin
            w_c16 = {4'b0000, w_rd, w_rs2, 2'b10};
        end else if (w_opcode == OpImm && w_f3 == 3'b101 && (w_f7 == 7'h00 || w_f7 == 7'h20)
                     && w_same && w_rd_p && w_rs2 != 5'd0) begin
            w_c16 = {5'b10000, w_f7[5], w_rd[2:0], w_rs2, 2'b01};
        end else if (w_opcode == OpImm && w_f3 == 3'b111 && w_same && w_rd_p && w_imm6_ok) begin
            w_c16 = {3'b100, w_imm6[5], 2'b10, w_rd[2:0], w_imm6[4:0], 2'b01};
        end else if (w_opcode == OpLoad && w_f3 == 3'b010 && w_rd_p && w_rs1_p
                     && w_imm_i[11:7] == 5'd0 && w_imm_i[1:0] == 2'b00) begin
            w_c16 = {3'b010, w_imm_i[5:3], w_rs1[2:0], w_imm_i[2], w_imm_i[6], w_rd[2:0],
                     2'b00};
        end else if (w_opcode == OpStore && w_f3 == 3'b010 && w_rs2_p && w_rs1_p
                     && w_imm_s[11:7] == 5'd0 && w_imm_s[1:0] == 2'b00) begin
            w_c16 = {3'b110, w_imm_s[5:3], w_rs1[2:0], w_imm_s[2], w_imm_s[6], w_rs2[2:0],
                     2'b00};
        end else if (w_opcode == OpLoad && w_f3 == 3'b010 && w_rs1 == 5'd2 && w_rd != 5'd0
                     && w_imm_i[11:8] == 4'd0 && w_imm_i[1:0] == 2'b00) begin
            w_c16 = {3'b010, w_imm_i[5], w_rd, w_imm_i[4:2], w_imm_i[7:6], 2'b10};
        end else if (w_opcode == OpStore && w_f3 == 3'b010 && w_rs1 == 5'd2
                     && w_imm_s[11:8] == 4'd0 && w_imm_s[1:0] == 2'b00) begin
            w_c16 = {3'b110, w_imm_s[5:2], w_imm_s[7:6], w_rs2, 2'b10};
        end else if (w_opcode == OpJalr && w_f3 == 3'b000 && w_imm_i == 12'd0
                     && w_rs1 != 5'd0 && (w_rd == 5'd0 || w_rd == 5'd1)) begin
            w_c16 = {3'b100, w_rd[0], w_rs1, 5'd0, 2'b10};
        end else begin
            w_is_c = 1'b0;
        end
    end

    // The output register frees up when empty or when its beat is taken this cycle
    assign w_out_free  = !r_out_valid || i_out_ready;
    assign o_in_ready  = (r_state != StPad) && w_out_free;
    assign w_accept    = i_in_valid && o_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_cmp_cnt   = r_cmp_cnt;

    always_comb begin
        w_state_next     = r_state;
        w_hold_next      = r_hold;
        w_out_valid_next = r_out_valid && !i_out_ready;
        w_out_data_next  = r_out_data;
        case (r_state)
            StEmpty: begin
                if (w_accept) begin
                    if (w_is_c && !i_in_last) begin
                        w_hold_next  = w_c16;
                        w_state_next = StHalf;
                    end else begin
                        w_out_valid_next = 1'b1;
                        w_out_data_next  = w_is_c ? {16'h0001, w_c16} : i_in_instr;
                    end
                end
            end
            StHalf: begin
                if (w_accept) begin
                    w_out_valid_next = 1'b1;
                    if (w_is_c) begin
                        w_out_data_next = {w_c16, r_hold};
                        w_hold_next     = 16'h0000;
                        w_state_next    = StEmpty;
                    end else begin
                        w_out_data_next = {i_in_instr[15:0], r_hold};
                        w_hold_next     = i_in_instr[31:16];
                        w_state_next    = i_in_last ? StPad : StHalf;
                    end
                end
            end
            StPad: begin
                // Trailing upper half is flushed with a c.nop filler
                if (w_out_free) begin
                    w_out_valid_next = 1'b1;
                    w_out_data_next  = {16'h0001, r_hold};
                    w_hold_next      = 16'h0000;
                    w_state_next     = StEmpty;
                end
            end
            default: begin
                w_state_next = StEmpty;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StEmpty;
            r_hold      <= 16'h0000;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'h0000_0000;
            r_cmp_cnt   <= 16'h0000;
        end else begin
            r_state     <= w_state_next;
            r_hold      <= w_hold_next;
            r_out_valid <= w_out_valid_next;
            r_out_data  <= w_out_data_next;
            if (w_accept && w_is_c && r_cmp_cnt != 16'hFFFF) begin
                r_cmp_cnt <= r_cmp_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rv32torv16_packer.sv
// Bench for rv32torv16_packer: directed vectors plus a random round-trip stream checked
// against a table built by expanding every legal RVC halfword.
module tb_rv32torv16_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [15:0] cmp_cnt;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    bit   [15:0] cmap[bit [31:0]];
    logic [31:0] cwords[$];
    int          m_state = 0;
    logic [15:0] m_hold = 16'h0;
    int unsigned m_cnt = 0;
    bit          use_model = 1'b0;
    bit          ready_rand = 1'b0;
    bit          ready_force = 1'b1;
    bit          mon_pending = 1'b0;
    logic [31:0] mon_data = 32'h0;

    rv32torv16_packer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_instr  (in_instr),
        .i_in_last   (in_last),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_cmp_cnt   (cmp_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] mk_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    // Expands the RVC subset the packer is allowed to emit; ok=0 for anything else
    function automatic void expand(input logic [15:0] h, output bit ok, output logic [31:0] w);
        logic [4:0]  rd;
        logic [4:0]  rs2;
        logic [4:0]  rdp;
        logic [4:0]  rs2p;
        logic [5:0]  imm6;
        logic [11:0] simm;
        logic [6:0]  off7;
        logic [7:0]  off8;
        rd   = h[11:7];
        rs2  = h[6:2];
        rdp  = {2'b01, h[9:7]};
        rs2p = {2'b01, h[4:2]};
        imm6 = {h[12], h[6:2]};
        simm = {{6{h[12]}}, imm6};
        ok   = 1'b0;
        w    = 32'h0;
        case (h[1:0])
            2'b00: begin
                off7 = {h[5], h[12:10], h[6], 2'b00};
                if (h[15:13] == 3'b010) begin
                    ok = 1'b1; w = mk_i({5'b0, off7}, rdp, 3'd2, rs2p, 7'h03);
                end else if (h[15:13] == 3'b110) begin
                    ok = 1'b1; w = mk_s({5'b0, off7}, rs2p, rdp, 3'd2, 7'h23);
                end
            end
            2'b01: begin
                case (h[15:13])
                    3'b000: begin
                        if (rd == 5'd0 && imm6 == 6'd0) begin
                            ok = 1'b1; w = 32'h0000_0013;
                        end else if (rd != 5'd0 && rd != 5'd2 && imm6 != 6'd0) begin
                            ok = 1'b1; w = mk_i(simm, rd, 3'd0, rd, 7'h13);
                        end
                    end
                    3'b010: begin
                        if (rd != 5'd0) begin
                            ok = 1'b1; w = mk_i(simm, 5'd0, 3'd0, rd, 7'h13);
                        end
                    end
                    3'b100: begin
                        case (h[11:10])
                            2'b00: if (!h[12] && rs2 != 5'd0) begin
                                ok = 1'b1; w = mk_r(7'h00, rs2, rdp, 3'd5, rdp, 7'h13);
                            end
                            2'b01: if (!h[12] && rs2 != 5'd0) begin
                                ok = 1'b1; w = mk_r(7'h20, rs2, rdp, 3'd5, rdp, 7'h13);
                            end
                            2'b10: begin
                                ok = 1'b1; w = mk_i(simm, rdp, 3'd7, rdp, 7'h13);
                            end
                            default: if (!h[12]) begin
                                ok = 1'b1;
                                case (h[6:5])
                                    2'b00:   w = mk_r(7'h20, rs2p, rdp, 3'd0, rdp, 7'h33);
                                    2'b01:   w = mk_r(7'h00, rs2p, rdp, 3'd4, rdp, 7'h33);
                                    2'b10:   w = mk_r(7'h00, rs2p, rdp, 3'd6, rdp, 7'h33);
                                    default: w = mk_r(7'h00, rs2p, rdp, 3'd7, rdp, 7'h33);
                                endcase
                            end
                        endcase
                    end
                    default: ok = 1'b0;
                endcase
            end
            2'b10: begin
                case (h[15:13])
                    3'b000: if (!h[12] && rd != 5'd0 && rs2 != 5'd0) begin
                        ok = 1'b1; w = mk_r(7'h00, rs2, rd, 3'd1, rd, 7'h13);
                    end
                    3'b010: if (rd != 5'd0) begin
                        off8 = {h[3:2], h[12], h[6:4], 2'b00};
                        ok = 1'b1; w = mk_i({4'b0, off8}, 5'd2, 3'd2, rd, 7'h03);
                    end
                    3'b110: begin
                        off8 = {h[8:7], h[12:9], 2'b00};
                        ok = 1'b1; w = mk_s({4'b0, off8}, rs2, 5'd2, 3'd2, 7'h23);
                    end
                    3'b100: begin
                        if (!h[12] && rs2 == 5'd0 && rd != 5'd0) begin
                            ok = 1'b1; w = mk_i(12'd0, rd, 3'd0, 5'd0, 7'h67);
                        end else if (!h[12] && rs2 != 5'd0 && rd != 5'd0) begin
                            ok = 1'b1; w = mk_r(7'h00, rs2, 5'd0, 3'd0, rd, 7'h33);
                        end else if (h[12] && rs2 == 5'd0 && rd == 5'd0) begin
                            ok = 1'b1; w = 32'h0010_0073;
                        end else if (h[12] && rs2 == 5'd0) begin
                            ok = 1'b1; w = mk_i(12'd0, rd, 3'd0, 5'd1, 7'h67);
                        end else if (h[12] && rd != 5'd0) begin
                            ok = 1'b1; w = mk_r(7'h00, rs2, rd, 3'd0, rd, 7'h33);
                        end
                    end
                    default: ok = 1'b0;
                endcase
            end
            default: ok = 1'b0;
        endcase
    endfunction

    task automatic model_accept(input logic [31:0] instr, input bit last);
        bit          is_c;
        logic [15:0] c;
        is_c = cmap.exists(instr);
        c    = is_c ? cmap[instr] : 16'h0;
        if (is_c) m_cnt++;
        if (m_state == 0) begin
            if (is_c && !last) begin
                m_hold = c; m_state = 1;
            end else begin
                exp_q.push_back(is_c ? {16'h0001, c} : instr);
            end
        end else if (is_c) begin
            exp_q.push_back({c, m_hold}); m_state = 0;
        end else begin
            exp_q.push_back({instr[15:0], m_hold});
            if (last) begin
                exp_q.push_back({16'h0001, instr[31:16]}); m_state = 0;
            end else begin
                m_hold = instr[31:16];
            end
        end
    endtask

    // Handshakes are decided at the negedge before the edge that completes them
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_pending = 1'b0;
        end else begin
            if (mon_pending) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, mon_data);
            end
            if (out_valid && out_ready) begin
                chk("beat_available", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) chk("beat", out_data, exp_q.pop_front());
                mon_pending = 1'b0;
            end else if (out_valid) begin
                mon_pending = 1'b1;
                mon_data    = out_data;
            end else begin
                mon_pending = 1'b0;
            end
        end
    end

    task automatic send(input logic [31:0] instr, input bit last);
        bit done;
        int budget;
        done     = 1'b0;
        budget   = 200;
        in_valid = 1'b1;
        in_instr = instr;
        in_last  = last;
        while (!done && budget > 0) begin
            @(negedge clk);
            if (in_ready) begin
                if (use_model) model_accept(instr, last);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            budget--;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!done) chk("send_timeout", done, 1'b1);
    endtask

    task automatic drain(input string tag);
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 2000) begin
            @(posedge clk);
            #1;
            b++;
        end
        chk(tag, exp_q.size(), 32'd0);
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] exp);
        @(negedge clk);
        chk(tag, cmp_cnt, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        m_state = 0;
        m_hold  = 16'h0;
        m_cnt   = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        logic [31:0] w;
        logic [31:0] iw;
        bit          il;
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] h;
            h = i[15:0];
            if (h[1:0] != 2'b11) begin
                expand(h, ok, w);
                if (ok && !cmap.exists(w)) begin
                    cmap[w] = h;
                    cwords.push_back(w);
                end
            end
        end

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid_during", out_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_cmp_cnt", cmp_cnt, 32'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Two compressibles pack into one word
        exp_q.push_back(32'h952e_0405);
        send(32'h0014_0413, 1'b0);
        send(32'h00b5_0533, 1'b0);
        drain("drain_two_c");
        check_cnt("cnt_two_c", 32'd2);

        // Misaligned 32-bit word ending the stream, followed by a pad beat
        exp_q.push_back(32'h50b7_428d);
        exp_q.push_back(32'h0001_1234);
        send(32'h0030_0293, 1'b0);
        send(32'h1234_50b7, 1'b1);
        @(negedge clk);
        chk("pad_in_ready", in_ready, 1'b0);
        chk("pad_beat1", out_data, 32'h50b7_428d);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pad_beat2_valid", out_valid, 1'b1);
        chk("pad_beat2", out_data, 32'h0001_1234);
        @(posedge clk);
        #1;
        drain("drain_pad");
        check_cnt("cnt_pad", 32'd3);

        // Passthrough: branch and out-of-range lw
        exp_q.push_back(32'h0000_0463);
        exp_q.push_back(32'h0804_a403);
        send(32'h0000_0463, 1'b0);
        send(32'h0804_a403, 1'b0);
        drain("drain_pass");
        check_cnt("cnt_pass", 32'd3);

        // Lone compressible with in_last
        exp_q.push_back(32'h0001_0405);
        send(32'h0014_0413, 1'b1);
        drain("drain_last_c");
        check_cnt("cnt_last_c", 32'd4);

        // Backpressure for five cycles
        exp_q.push_back(32'h1234_50b7);
        exp_q.push_back(32'h0000_0463);
        ready_force = 1'b0;
        send(32'h1234_50b7, 1'b0);
        in_valid = 1'b1;
        in_instr = 32'h0000_0463;
        in_last  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_data", out_data, 32'h1234_50b7);
            @(posedge clk);
            #1;
        end
        ready_force = 1'b1;
        send(32'h0000_0463, 1'b0);
        drain("drain_bp");
        check_cnt("cnt_bp", 32'd4);

        // Reset discards a held halfword
        send(32'h0014_0413, 1'b0);
        do_reset(1);
        @(negedge clk);
        chk("rst2_out_valid", out_valid, 1'b0);
        chk("rst2_cmp_cnt", cmp_cnt, 32'h0);
        @(posedge clk);
        #1;
        exp_q.push_back(32'h0001_952e);
        send(32'h00b5_0533, 1'b1);
        drain("drain_rst2");
        check_cnt("cnt_rst2", 32'd1);

        // Random round-trip stream with random sink stalls and idle gaps
        do_reset(2);
        use_model  = 1'b1;
        ready_rand = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                iw = cwords[$urandom_range(0, cwords.size() - 1)];
            end else begin
                iw = $urandom() | 32'h3;
            end
            il = (i == 9999) || ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
            send(iw, il);
        end
        drain("drain_rand");
        ready_rand = 1'b0;
        check_cnt("cnt_rand", m_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
